// File: rtl/mult_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mult_seq_ctrl_pkg
//   Shared definitions for the sequential MULT/MULTU controller:
//   - 3-bit FSM state encoding (localparams plus the typed enum built on them)
//   - iteration count and counter width
//   - fixed start-to-done latencies for unsigned and signed operations
//   - small helper that tells whether a state counts as busy
// ---------------------------------------------------------------------------
package mult_seq_ctrl_pkg;

    localparam int unsigned ITERS = 32;
    localparam int unsigned CNT_W = 5;

    // Edges from the start-sampling edge to the edge after which done is high
    localparam int unsigned LAT_U = 32;
    localparam int unsigned LAT_S = 36;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_NEG_A  = 3'd1;
    localparam logic [2:0] ST_NEG_B  = 3'd2;
    localparam logic [2:0] ST_ITER   = 3'd3;
    localparam logic [2:0] ST_NEG_LO = 3'd4;
    localparam logic [2:0] ST_NEG_HI = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    typedef enum logic [2:0] {
        StIdle  = ST_IDLE,
        StNegA  = ST_NEG_A,
        StNegB  = ST_NEG_B,
        StIter  = ST_ITER,
        StNegLo = ST_NEG_LO,
        StNegHi = ST_NEG_HI,
        StDone  = ST_DONE
    } state_e;

    function automatic logic is_busy_state(input state_e st);
        return (st != StIdle) && (st != StDone);
    endfunction

endpackage

// File: rtl/mult_seq_ctrl_add32.sv
// ---------------------------------------------------------------------------
// mult_seq_ctrl_add32
//   Plain 32-bit ripple-carry adder with no carry-in. Shared by every step of
//   the multiply sequence (operand negation, accumulate, result negation).
//
//   x_i      in  32  first operand
//   y_i      in  32  second operand
//   sum_o    out 32  x_i + y_i, low 32 bits
//   carry_o  out 1   carry out of bit 31
// ---------------------------------------------------------------------------
module mult_seq_ctrl_add32 (
    input  logic [31:0] x_i,
    input  logic [31:0] y_i,
    output logic [31:0] sum_o,
    output logic        carry_o
);

    always_comb begin
        logic carry;
        carry = 1'b0;
        sum_o = '0;
        for (int i = 0; i < 32; i++) begin
            sum_o[i] = x_i[i] ^ y_i[i] ^ carry;
            carry    = (x_i[i] & y_i[i]) | (carry & (x_i[i] ^ y_i[i]));
        end
        carry_o = carry;
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mult_seq_ctrl
//   Multi-cycle shift-and-add multiplier controller for MIPS MULT/MULTU.
//   One shared 32-bit adder is sequenced to build a 64-bit {hi, lo} product.
//   Signed operands are converted to magnitudes first (NEG_A, NEG_B) and the
//   result is negated afterwards (NEG_LO, NEG_HI) when the signs differ.
//   Latency is fixed: 32 edges unsigned, 36 edges signed.
//
//   clk_i        in  1   rising-edge clock
//   rst_i        in  1   asynchronous reset, active-high
//   start_i      in  1   request; only honoured in IDLE or DONE
//   is_signed_i  in  1   1 = MULT, 0 = MULTU; sampled with start_i
//   a_i          in  32  multiplicand; sampled with start_i
//   b_i          in  32  multiplier; sampled with start_i
//   busy_o       out 1   high in every state except IDLE and DONE
//   done_o       out 1   one-cycle pulse, high while in DONE
//   hi_o         out 32  product bits [63:32]
//   lo_o         out 32  product bits [31:0]
// ---------------------------------------------------------------------------
module mult_seq_ctrl #(
    parameter int unsigned WIDTH = 32,  // only 32 supported (fixed adder)
    parameter int unsigned ITERS = 32   // must equal WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    import mult_seq_ctrl_pkg::*;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(ITERS - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sgn_q;
    logic               neg_res_q;
    logic               c_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   add_x;
    logic [WIDTH-1:0]   add_y;
    logic [WIDTH-1:0]   add_sum;
    logic               add_co;
    logic               accept;

    // start is only honoured when no operation is in flight
    assign accept = start_i && ((state_q == StIdle) || (state_q == StDone));

    // Adder operands depend on the state alone
    always_comb begin
        add_x = '0;
        add_y = '0;
        unique case (state_q)
            StNegA: begin
                add_x = ~mcand_q;
                add_y = WIDTH'(1);
            end
            StNegB, StNegLo: begin
                add_x = ~lo_q;
                add_y = WIDTH'(1);
            end
            StIter: begin
                add_x = hi_q;
                add_y = mcand_q;
            end
            StNegHi: begin
                add_x = ~hi_q;
                add_y = {{(WIDTH-1){1'b0}}, c_q};
            end
            default: ;
        endcase
    end

    mult_seq_ctrl_add32 u_add32 (
        .x_i     (add_x),
        .y_i     (add_y),
        .sum_o   (add_sum),
        .carry_o (add_co)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    state_d = is_signed_i ? StNegA : StIter;
                end else begin
                    state_d = StIdle;
                end
            end
            StNegA:  state_d = StNegB;
            StNegB:  state_d = StIter;
            StIter: begin
                if (cnt_q == CntLast) begin
                    state_d = sgn_q ? StNegLo : StDone;
                end
            end
            StNegLo: state_d = StNegHi;
            StNegHi: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            sgn_q     <= 1'b0;
            neg_res_q <= 1'b0;
            c_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            // Outputs registered from the next state so they track state_q exactly
            busy_q  <= is_busy_state(state_d);
            done_q  <= (state_d == StDone);

            unique case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        mcand_q   <= a_i;
                        lo_q      <= b_i;
                        sgn_q     <= is_signed_i;
                        neg_res_q <= is_signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        hi_q      <= '0;
                        cnt_q     <= '0;
                    end
                end
                StNegA: begin
                    // 0x80000000 maps to itself and is then read as unsigned 2^31
                    if (mcand_q[WIDTH-1]) begin
                        mcand_q <= add_sum;
                    end
                end
                StNegB: begin
                    if (lo_q[WIDTH-1]) begin
                        lo_q <= add_sum;
                    end
                end
                StIter: begin
                    // Multiplier bits shift out of lo while product bits shift in
                    if (lo_q[0]) begin
                        {hi_q, lo_q} <= {add_co, add_sum, lo_q[WIDTH-1:1]};
                    end else begin
                        {hi_q, lo_q} <= {1'b0, hi_q, lo_q[WIDTH-1:1]};
                    end
                    cnt_q <= cnt_q + 1'b1;
                end
                StNegLo: begin
                    // Carry out of ~lo + 1 ripples into the upper half
                    if (neg_res_q) begin
                        lo_q <= add_sum;
                        c_q  <= add_co;
                    end else begin
                        c_q  <= 1'b0;
                    end
                end
                StNegHi: begin
                    if (neg_res_q) begin
                        hi_q <= add_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;
    import mult_seq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0] prod;
        int          lat;
    } exp_t;

    exp_t sb[$];

    mult_seq_ctrl #(
        .WIDTH (32),
        .ITERS (32)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .is_signed_i (is_signed),
        .a_i         (a),
        .b_i         (b),
        .busy_o      (busy),
        .done_o      (done),
        .hi_o        (hi),
        .lo_o        (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic sg, input logic [31:0] x,
                                             input logic [31:0] y);
        longint sx;
        longint sy;
        if (sg) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    // Drive a request at a negedge and record what it must produce
    task automatic issue(input logic sg, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        start     = 1'b1;
        is_signed = sg;
        a         = x;
        b         = y;
        e.prod    = ref_prod(sg, x, y);
        e.lat     = sg ? int'(LAT_S) : int'(LAT_U);
        sb.push_back(e);
    endtask

    // Follows an issue(); returns at the negedge where done is seen.
    // glitch_at >= 0 raises start at that many edges after acceptance.
    task automatic collect(input string tag, input int glitch_at, input bit chained);
        exp_t        e;
        int          n;
        logic [63:0] res;
        @(posedge clk);
        @(negedge clk);
        n = 0;
        while (done !== 1'b1 && n < 64) begin
            check({tag, " busy"}, {63'b0, busy}, 64'd1);
            if (n == glitch_at) begin
                start     = 1'b1;
                is_signed = 1'b1;
                a         = 32'hDEAD_BEEF;
                b         = 32'h1234_5678;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            check({tag, " scoreboard"}, 64'd0, 64'd1);
            return;
        end
        e   = sb.pop_front();
        res = {hi, lo};
        check({tag, " latency"}, 64'(n), 64'(e.lat));
        check({tag, " product"}, res, e.prod);
        check({tag, " busy@done"}, {63'b0, busy}, 64'd0);
        if (!chained) begin
            start = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check({tag, " done pulse"}, {63'b0, done}, 64'd0);
            check({tag, " idle busy"}, {63'b0, busy}, 64'd0);
            check({tag, " hold"}, {hi, lo}, res);
        end
    endtask

    logic [31:0] specials [5];
    logic [31:0] x;
    logic [31:0] y;
    logic        sg;

    initial begin
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;

        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        #1;
        check("reset outputs", {30'b0, busy, done, hi}, 64'd0);
        check("reset lo", {32'b0, lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        collect("multu ones", -1, 1'b0);

        issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
        collect("mult -1x1", -1, 1'b0);

        issue(1'b1, 32'h8000_0000, 32'h8000_0000);
        collect("mult min*min", -1, 1'b0);

        issue(1'b1, 32'h0000_0007, 32'hFFFF_FFFD);
        collect("mult 7x-3", -1, 1'b0);

        // Back-to-back: second request issued while in DONE; stray start mid-ITER
        issue(1'b0, 32'd3, 32'd5);
        collect("b2b first", -1, 1'b1);
        issue(1'b0, 32'h0001_0000, 32'h0001_0000);
        collect("b2b second", 10, 1'b0);

        // Async reset in the middle of ITER, between clock edges
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (17) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst mid busy/done/hi", {30'b0, busy, done, hi}, 64'd0);
        check("rst mid lo", {32'b0, lo}, 64'd0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        check("rst held busy", {63'b0, busy}, 64'd0);
        rst = 1'b0;
        issue(1'b1, 32'h0000_0007, 32'hFFFF_FFFD);
        collect("after rst", -1, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            sg = 1'($urandom_range(0, 1));
            x  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            y  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            issue(sg, x, y);
            collect($sformatf("rand%0d %s %h*%h", i, sg ? "s" : "u", x, y), -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Multi-cycle multiplier controller for the MIPS MULT/MULTU path.
- Sequences one shared 32-bit ripple adder, Add32 (X, Y -> out, carry; no carry-in), to produce a 64-bit HI/LO product by shift-and-add.
- Signed operation uses magnitude pre-negation and result post-negation through the same adder.
- Sits beside the ALU; the HI/LO register file takes hi/lo when done pulses.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported because the adder is fixed 32-bit.
- ITERS, 32, number of shift-add iterations. Must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  request; sampled only in IDLE or DONE
- is_signed  in  1  1 = MULT, 0 = MULTU; sampled with start
- a  in  32  multiplicand; sampled with start
- b  in  32  multiplier; sampled with start
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  one-cycle pulse; high exactly while state = DONE
- hi  out  32  product bits [63:32]
- lo  out  32  product bits [31:0]

Behaviour:
- Reset (async, any time, including mid-operation): state = IDLE; busy = 0, done = 0, hi = 0, lo = 0; iteration counter = 0; operand registers = 0. Any operation in flight is abandoned.
- State encoding: IDLE, NEG_A, NEG_B, ITER, NEG_LO, NEG_HI, DONE.
- Accept: start = 1 in IDLE or DONE. On that edge:
  - latch a into mcand, b into lo, is_signed into sgn;
  - latch neg_res = is_signed & (a[31] ^ b[31]);
  - clear hi and the counter;
  - next state = NEG_A if is_signed, else ITER.
- start while busy: ignored, no effect.
- NEG_A (1 cycle): adder X = ~mcand, Y = 1. If mcand[31], mcand <= out. Go to NEG_B.
- NEG_B (1 cycle): same operation applied to lo. Go to ITER.
- Both NEG states always take their cycle, so latency is fixed.
- 0x80000000 negates to itself; it is then treated as an unsigned magnitude, which is correct.
- ITER (32 cycles): adder X = hi, Y = mcand.
  - If lo[0] = 1: {hi, lo} <= {carry, out, lo[31:1]}.
  - Else: {hi, lo} <= {1'b0, hi, lo[31:1]}.
  - Counter increments each cycle. After counter = 31, go to NEG_LO if sgn, else DONE.
- NEG_LO (1 cycle): X = ~lo, Y = 1. If neg_res, lo <= out and c_reg <= carry; else c_reg <= 0.
- NEG_HI (1 cycle): X = ~hi, Y = {31'b0, c_reg}. If neg_res, hi <= out. Go to DONE.
- DONE (1 cycle): done = 1, busy = 0. Next state = IDLE, or the accept path if start = 1 (back-to-back).
- hi/lo hold their final values from DONE until the next accept edge.
- Latency, counted from the edge that samples start to the edge after which done = 1: unsigned 32 edges, signed 36 edges. Fixed, independent of data.
- Adder inputs are muxed purely by state. In IDLE and DONE the adder inputs are X = 0, Y = 0.
- hi/lo are not valid while busy and may show intermediate values.

Decomposition:
- Shared package holds:
  - state encoding localparams (3-bit);
  - ITERS and the counter width (5 bits);
  - the latency constants LAT_U = 32 and LAT_S = 36 for the bench.
- One sub-module instance: the existing Add32 ripple adder.
- Operand muxing, registers and FSM stay in this module. Expected size about 150-200 lines.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done 32 edges after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for the 32 cycles before done.
- MULT a=0xFFFFFFFF (-1), b=0x00000001 -> done after 36 edges; hi=0xFFFFFFFF, lo=0xFFFFFFFF.
- MULT a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000; MULT a=0x00000007, b=0xFFFFFFFD -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Back-to-back: MULTU 3x5 with start held high in DONE, followed by MULTU 0x10000x0x10000 -> first result hi=0, lo=15 with one-cycle done; second done 32 edges later with hi=1, lo=0; no IDLE cycle between; a start pulse at ITER cycle 10 is ignored.
- Async rst asserted at ITER cycle 17 (between clock edges) -> busy, done, hi, lo immediately 0; state IDLE; a new start after release completes with correct result and normal latency.
- Random 1,000 signed and unsigned pairs including 0, 1, and all-ones -> {hi, lo} equals the 64-bit reference product; latency always 32 or 36.
